// File: rtl/chmux_scan.sv
// ---------------------------------------------------------------------------
// chmux_scan
//   N-channel, W-bit registered multiplexer with manual select, round-robin
//   auto-scan (fixed dwell per channel), sample-and-hold and a one-cycle
//   channel-change strobe. Every output comes straight from a flop.
//
// Optional build macro: CHMUX_MASK_EN
//   Adds ch_mask[NCH]. Scan then skips masked channels, and a masked channel
//   drives dout as zero.
//
// Parameters
//   NCH   : number of input channels (2..16)
//   W     : bits per channel (1..8)
//   DWELL : clocks spent on each channel while scanning (>=1)
//   SELW  : derived select width, not user-set
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   ena       in   global enable, 0 freezes all state
//   din       in   packed channel data, channel k = din[k*W +: W]
//   sel       in   manual channel select (clamped to NCH-1)
//   mode      in   0 = manual, 1 = auto-scan
//   hold      in   1 = freeze channel, dwell counter and dout
//   ch_mask   in   (CHMUX_MASK_EN only) per-channel enable
//   dout      out  registered selected data
//   cur_ch    out  channel currently driving dout
//   ch_strobe out  one-cycle pulse when cur_ch changes
//
// Channel selection
//   mode | meaning
//   0    | manual: cur_ch follows clamped sel, dwell counter reloads
//   1    | scan  : stay for DWELL update edges, then step to next channel
// ---------------------------------------------------------------------------
module chmux_scan #(
    parameter int NCH   = 4,
    parameter int W     = 1,
    parameter int DWELL = 16,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NCH*W-1:0]  din,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              hold,
`ifdef CHMUX_MASK_EN
    input  logic [NCH-1:0]    ch_mask,
`endif
    output logic [W-1:0]      dout,
    output logic [SELW-1:0]   cur_ch,
    output logic              ch_strobe
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    // Dwell timer counts down the edges left on the current channel;
    // zero is the terminal count where scan advances.
    localparam logic [CW-1:0]   DWELL_TC = CW'(DWELL - 1);
    localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);

    logic [W-1:0]    r_dout;
    logic [SELW-1:0] r_cur_ch;
    logic [CW-1:0]   r_dwell_left;
    logic            r_strobe;

    logic [W-1:0]    w_ch [NCH];
    logic [SELW-1:0] w_sel_clamped;
    logic [SELW-1:0] w_scan_ch;
    logic [SELW-1:0] w_nxt_ch;
    logic [CW-1:0]   w_nxt_dwell;
    logic [W-1:0]    w_nxt_dout;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign w_ch[k] = din[k*W +: W];
    end

    // Extra MSB so the compare is meaningful when NCH is a power of two.
    assign w_sel_clamped = ({1'b0, sel} >= (SELW+1)'(NCH)) ? LAST_CH : sel;

`ifdef CHMUX_MASK_EN
    // First enabled channel after cur_ch, searching with wrap. The final
    // candidate is cur_ch itself, so a lone enabled channel stays put and
    // an all-zero mask leaves cur_ch unchanged.
    always_comb begin
        logic [SELW-1:0] cand;
        logic            found;
        cand      = '0;
        found     = 1'b0;
        w_scan_ch = r_cur_ch;
        for (int i = 1; i <= NCH; i++) begin
            cand = SELW'((int'(r_cur_ch) + i) % NCH);
            if (!found && ch_mask[cand]) begin
                w_scan_ch = cand;
                found     = 1'b1;
            end
        end
    end

    assign w_nxt_dout = ch_mask[w_nxt_ch] ? w_ch[w_nxt_ch] : '0;
`else
    assign w_scan_ch  = (r_cur_ch == LAST_CH) ? '0 : r_cur_ch + 1'b1;
    assign w_nxt_dout = w_ch[w_nxt_ch];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_cur_ch     <= '0;
            r_dwell_left <= DWELL_TC;
            r_strobe     <= 1'b0;
        end else if (ena && !hold) begin
            r_dout       <= w_nxt_dout;
            r_cur_ch     <= w_nxt_ch;
            r_dwell_left <= w_nxt_dwell;
            r_strobe     <= (w_nxt_ch != r_cur_ch);
        end else begin
            r_strobe     <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        w_nxt_ch    = r_cur_ch;
        w_nxt_dwell = r_dwell_left;
        if (!mode) begin
            w_nxt_ch    = w_sel_clamped;
            w_nxt_dwell = DWELL_TC;
        end else if (r_dwell_left == '0) begin
            w_nxt_ch    = w_scan_ch;
            w_nxt_dwell = DWELL_TC;
        end else begin
            w_nxt_dwell = r_dwell_left - 1'b1;
        end
    end

    // Outputs
    always_comb begin
        dout      = r_dout;
        cur_ch    = r_cur_ch;
        ch_strobe = r_strobe;
    end

endmodule

// File: tb/tb_chmux_scan.sv
// ---------------------------------------------------------------------------
// tb_chmux_scan
//   Two instances share one stimulus stream: NCH=4 and NCH=3 (for the select
//   clamp), both W=2, DWELL=3. A behavioural model holds the current channel,
//   an up-counting dwell count and the expected outputs, and is updated from
//   the channel rules each clock edge. Directed test-plan steps come first,
//   followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_chmux_scan;

    localparam int W     = 2;
    localparam int DWELL = 3;

    logic       clk = 1'b0;
    logic       rst_n, ena, mode, hold;
    logic [7:0] din;
    logic [1:0] sel;
    logic [3:0] ch_mask;
    logic [1:0] dout4, dout3, cur4, cur3;
    logic       stb4, stb3;

    always #5 clk = ~clk;

    chmux_scan #(.NCH(4), .W(W), .DWELL(DWELL)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din       (din),
        .sel       (sel),
        .mode      (mode),
        .hold      (hold),
`ifdef CHMUX_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .dout      (dout4),
        .cur_ch    (cur4),
        .ch_strobe (stb4)
    );

    chmux_scan #(.NCH(3), .W(W), .DWELL(DWELL)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .din       (din[5:0]),
        .sel       (sel),
        .mode      (mode),
        .hold      (hold),
`ifdef CHMUX_MASK_EN
        .ch_mask   (ch_mask[2:0]),
`endif
        .dout      (dout3),
        .cur_ch    (cur3),
        .ch_strobe (stb3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: index 0 = NCH 4, index 1 = NCH 3
    int nch_of [2] = '{4, 3};
    int m_cur  [2] = '{0, 0};
    int m_cnt  [2] = '{0, 0};
    int m_dout [2] = '{0, 0};
    int m_stb  [2] = '{0, 0};

    function automatic int next_enabled(input int cur, input int n, input logic [3:0] msk);
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (cur + k) % n;
            if (msk[c[1:0]]) return c;
        end
        return cur;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int n;
            int nxt;
            logic [3:0] msk;
            n   = nch_of[i];
            msk = (i == 0) ? ch_mask : (ch_mask & 4'b0111);
            if (!rst_n) begin
                m_cur[i] = 0; m_cnt[i] = 0; m_dout[i] = 0; m_stb[i] = 0;
            end else if (ena && !hold) begin
                nxt = m_cur[i];
                if (!mode) begin
                    nxt      = (int'(sel) >= n) ? n - 1 : int'(sel);
                    m_cnt[i] = 0;
                end else if (m_cnt[i] == DWELL - 1) begin
                    m_cnt[i] = 0;
                    nxt      = next_enabled(m_cur[i], n, msk);
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                m_stb[i]  = (nxt != m_cur[i]) ? 1 : 0;
                m_cur[i]  = nxt;
                m_dout[i] = msk[nxt[1:0]] ? ((int'(din) >> (2 * nxt)) & 3) : 0;
            end else begin
                m_stb[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("dout4",   32'(dout4), 32'(m_dout[0]));
        chk("cur4",    32'(cur4),  32'(m_cur[0]));
        chk("strobe4", 32'(stb4),  32'(m_stb[0]));
        chk("dout3",   32'(dout3), 32'(m_dout[1]));
        chk("cur3",    32'(cur3),  32'(m_cur[1]));
        chk("strobe3", 32'(stb3),  32'(m_stb[1]));
    endtask

    initial begin
        logic [1:0] frozen;
        rst_n = 1'b0; ena = 1'b1; mode = 1'b1; hold = 1'b0;
        sel = 2'd0; din = 8'b11_10_01_00; ch_mask = 4'hF;
        #2;

        // 1: reset with scan requested, then first advance
        step(); step();
        chk("rst_dout",   32'(dout4), 0);
        chk("rst_cur",    32'(cur4),  0);
        chk("rst_strobe", 32'(stb4),  0);
        rst_n = 1'b1;
        step(); step();
        chk("p1_cur_before", 32'(cur4), 0);
        step();
        chk("p1_adv_cur",    32'(cur4),  1);
        chk("p1_adv_dout",   32'(dout4), 1);
        chk("p1_adv_strobe", 32'(stb4),  1);
        step();
        chk("p1_strobe_one", 32'(stb4),  0);

        // 2: manual select
        mode = 1'b0; sel = 2'd2;
        step();
        chk("p2_dout",   32'(dout4), 2);
        chk("p2_cur",    32'(cur4),  2);
        chk("p2_strobe", 32'(stb4),  1);
        step();
        chk("p2_strobe_off", 32'(stb4), 0);

        // 3: clamp on the 3-channel instance
        sel = 2'd3;
        step();
        chk("p3_clamp_cur",  32'(cur3),  2);
        chk("p3_clamp_dout", 32'(dout3), 2);
        chk("p3_cur4",       32'(cur4),  3);

        // 4: scan from ch3 with hold at cnt=1, then wrap to ch0
        mode = 1'b1;
        step();
        hold = 1'b1;
        repeat (5) step();
        chk("p4_hold_cur",    32'(cur4), 3);
        chk("p4_hold_strobe", 32'(stb4), 0);
        hold = 1'b0;
        step();
        chk("p4_rel_cur", 32'(cur4), 3);
        step();
        chk("p4_wrap_cur",    32'(cur4),  0);
        chk("p4_wrap_dout",   32'(dout4), 0);
        chk("p4_wrap_strobe", 32'(stb4),  1);

        // 5: ena low freezes, reset still applies with ena low
        step(); step();
        ena    = 1'b0;
        frozen = cur4;
        din    = 8'hFF;
        repeat (4) step();
        chk("p5_frozen_cur", 32'(cur4), 32'(frozen));
        rst_n = 1'b0;
        step();
        chk("p5_rst_cur",  32'(cur4),  0);
        chk("p5_rst_dout", 32'(dout4), 0);
        rst_n = 1'b1; ena = 1'b1; din = 8'b11_10_01_00;

`ifdef CHMUX_MASK_EN
        // 6: masked scan 1,3,1,3 then all-masked
        ch_mask = 4'b1010; mode = 1'b0; sel = 2'd1;
        step();
        mode = 1'b1;
        repeat (3) step();
        chk("p6_cur_3", 32'(cur4), 3);
        repeat (3) step();
        chk("p6_cur_1", 32'(cur4), 1);
        ch_mask = 4'b0000;
        repeat (3) step();
        chk("p6_zero_dout",   32'(dout4), 0);
        chk("p6_zero_strobe", 32'(stb4),  0);
        ch_mask = 4'hF;
`endif

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            din   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) sel  = 2'($urandom);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            hold  = ($urandom_range(0, 7) == 0);
            ena   = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 63) != 0);
`ifdef CHMUX_MASK_EN
            if ($urandom_range(0, 15) == 0) ch_mask = 4'($urandom);
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chmux_scan.md
Name: chmux_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer; next generation of the single-bit 2:1 select cell.
- Adds an auto-scan mode: a dwell counter steps through channels in round-robin.
- Also adds a hold (sample-and-hold) control and a channel-change strobe.
- Sits between the dedicated input pins and output logic. Scan drives a time-multiplexed display or probe; manual select gives direct routing.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 1, bits per channel (1..8).
- DWELL, 16, clock cycles spent on each channel in scan mode (>=1).
- SELW, derived localparam = max(1, clog2(NCH)); not user-set.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- ena  input  1  global enable; 0 freezes all state.
- din  input  NCH*W  packed channel data; channel k = din[k*W +: W].
- sel  input  SELW  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- hold  input  1  1 = freeze channel, counter and dout.
- dout  output  W  registered selected data.
- cur_ch  output  SELW  channel currently driving dout.
- ch_strobe  output  1  one-cycle pulse when cur_ch changes.

Behaviour:
- Reset:
  - The only reset is rst_n low at a rising clk edge: synchronous, active-low. There is no asynchronous path.
  - Reset values: dout=0, cur_ch=0, ch_strobe=0, dwell counter cnt=0.
  - Reset overrides ena, hold and mode. Reset mid-scan returns to channel 0 with cnt=0.
- Update condition: an edge updates state only when ena=1 and hold=0. Otherwise dout, cur_ch and cnt hold, and ch_strobe<=0.
- Next channel, manual mode (mode=0):
  - next_ch = sel, clamped to NCH-1 if sel>=NCH.
  - cnt<=0.
- Next channel, scan mode (mode=1):
  - If cnt==DWELL-1: next_ch = cur_ch+1, wrapping NCH-1 -> 0, and cnt<=0.
  - Otherwise next_ch = cur_ch and cnt<=cnt+1.
- On each update edge:
  - cur_ch<=next_ch.
  - dout<=din slice of next_ch, so dout and cur_ch are always consistent.
  - ch_strobe<=(next_ch!=cur_ch).
- Latency: din or sel to dout is 1 cycle. No combinational path from any input to any output.
- Mode switch manual->scan: scan starts from the current cur_ch with cnt=0. The first advance comes DWELL update edges after the switch.
- Mode switch scan->manual: takes effect on the first edge. cur_ch jumps to sel and cnt clears.
- Hold:
  - Asserted mid-dwell: cnt is frozen, not cleared. Scan resumes with the remaining dwell when hold releases.
  - Asserted on the edge where an advance would occur: the advance is suppressed, and happens on the first edge after release.
- DWELL=1: channel advances on every update edge, and ch_strobe stays high continuously for NCH>1.
- NCH=2, W=1, mode=0: degenerates to a registered 2:1 mux.
- Internal state: the only FSM-like state is cnt (width clog2(DWELL), min 1) plus cur_ch. There are no other states.

Optional Feature:
- Macro: CHMUX_MASK_EN.
- With the macro defined:
  - Adds input port ch_mask [NCH]; bit k=1 means channel k is enabled.
  - Scan advance goes to the next enabled channel after cur_ch, searching with wrap.
  - If cur_ch is the only enabled channel, it stays and there is no strobe.
  - If ch_mask==0, cur_ch holds, dout<=0 and no strobe.
  - Manual select of a masked channel: cur_ch<=sel (clamped) and dout<=0.
  - Masking the current channel mid-dwell forces dout<=0 on the next update edge. The dwell continues.
- Without the macro: no ch_mask port, all channels enabled, behaviour exactly as above.

Test Plan (NCH=4, W=2, DWELL=3, din={ch3=2'b11, ch2=2'b10, ch1=2'b01, ch0=2'b00}):
1. Hold rst_n=0 for 2 edges with ena=1, mode=1 -> dout=0, cur_ch=0, ch_strobe=0. After release, cur_ch stays 0 for 3 edges, then becomes 1 with dout=2'b01 and a 1-cycle ch_strobe.
2. Manual: mode=0, sel=2 -> one edge later dout=2'b10, cur_ch=2, ch_strobe=1. Next edge with sel=2 unchanged: ch_strobe=0.
3. Manual clamp: NCH=3 build, sel=3 -> cur_ch=2, dout=din ch2.
4. Scan wrap plus hold: run scan to cur_ch=3. Assert hold for 5 edges at cnt=1 -> no change. Release: advances to 0 after 2 more edges, dout=2'b00, strobe=1.
5. ena=0 for 4 edges mid-scan, then rst_n=0 with ena=0 -> state frozen while ena=0, reset still clears on the reset edge.
6. CHMUX_MASK_EN: ch_mask=4'b1010, scan from 1 -> sequence 1,3,1,3 every 3 edges. ch_mask=0 -> dout=0, no strobe.
